// File: rtl/cache_pmem_arbiter_if.sv
// Bundle of cache-miss and physical-memory port signals seen by the arbiter.
// The slave modport is the arbiter's view; master is the caches plus memory.
interface cache_pmem_arbiter_if #(
   parameter int s_line = 256,
   parameter int s_addr = 32
);
   logic              i_pmem_read;
   logic [s_addr-1:0] i_pmem_address;
   logic [s_line-1:0] i_pmem_rdata;
   logic              i_pmem_resp;

   logic              d_pmem_read;
   logic              d_pmem_write;
   logic [s_addr-1:0] d_pmem_address;
   logic [s_line-1:0] d_pmem_wdata;
   logic [s_line-1:0] d_pmem_rdata;
   logic              d_pmem_resp;

   logic              pmem_read;
   logic              pmem_write;
   logic [s_addr-1:0] pmem_address;
   logic [s_line-1:0] pmem_wdata;
   logic [s_line-1:0] pmem_rdata;
   logic              pmem_resp;

   modport slave (
      input  i_pmem_read, i_pmem_address,
      output i_pmem_rdata, i_pmem_resp,
      input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
      output d_pmem_rdata, d_pmem_resp,
      output pmem_read, pmem_write, pmem_address, pmem_wdata,
      input  pmem_rdata, pmem_resp
   );

   modport master (
      output i_pmem_read, i_pmem_address,
      input  i_pmem_rdata, i_pmem_resp,
      output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
      input  d_pmem_rdata, d_pmem_resp,
      input  pmem_read, pmem_write, pmem_address, pmem_wdata,
      output pmem_rdata, pmem_resp
   );
endinterface

// File: rtl/cache_pmem_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between the I-cache
// and D-cache miss paths, with saturating grant/conflict debug counters.
//
// state  | meaning
// IDLE   | no transaction; arbitrate and latch the winner on this edge
// BUSY_I | I-side fill in flight, memory strobes from latched registers
// BUSY_D | D-side fill or writeback in flight
module cache_pmem_arbiter #(
   parameter int s_line = 256,
   parameter int s_addr = 32,
   parameter int cnt_w  = 32
) (
   input  logic             clk,
   input  logic             rst,
   cache_pmem_arbiter_if.slave bus,
   output logic [cnt_w-1:0] i_grant_cnt,
   output logic [cnt_w-1:0] d_grant_cnt,
   output logic [cnt_w-1:0] conflict_cnt,
   output logic             op_error
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

   state_t            state, state_next;
   logic              last_d;
   logic              lat_write;
   logic [s_addr-1:0] lat_addr;
   logic [s_line-1:0] lat_wdata;

   logic req_i, req_d, grant_i, grant_d, busy;

   assign req_i   = bus.i_pmem_read;
   assign req_d   = bus.d_pmem_read | bus.d_pmem_write;
   // On a tie the side that did not win last time goes first.
   assign grant_i = (state == IDLE) & req_i & (~req_d | last_d);
   assign grant_d = (state == IDLE) & req_d & ~grant_i;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next      = state;
      busy            = 1'b0;
      bus.i_pmem_resp = 1'b0;
      bus.d_pmem_resp = 1'b0;
      case (state)
         IDLE: begin
            if (grant_i)      state_next = BUSY_I;
            else if (grant_d) state_next = BUSY_D;
         end
         BUSY_I: begin
            busy            = 1'b1;
            bus.i_pmem_resp = bus.pmem_resp;
            if (bus.pmem_resp) state_next = IDLE;
         end
         BUSY_D: begin
            busy            = 1'b1;
            bus.d_pmem_resp = bus.pmem_resp;
            if (bus.pmem_resp) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Strobes are decoded from the state register so reset drops them at once.
   assign bus.pmem_read    = busy & ~lat_write;
   assign bus.pmem_write   = busy & lat_write;
   assign bus.pmem_address = lat_addr;
   assign bus.pmem_wdata   = lat_wdata;
   assign bus.i_pmem_rdata = bus.pmem_rdata;
   assign bus.d_pmem_rdata = bus.pmem_rdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_d       <= 1'b1;
         lat_write    <= 1'b0;
         lat_addr     <= '0;
         lat_wdata    <= '0;
         i_grant_cnt  <= '0;
         d_grant_cnt  <= '0;
         conflict_cnt <= '0;
         op_error     <= 1'b0;
      end else begin
         if (grant_i) begin
            lat_addr  <= bus.i_pmem_address;
            lat_write <= 1'b0;
            last_d    <= 1'b0;
            if (~&i_grant_cnt) i_grant_cnt <= i_grant_cnt + cnt_w'(1);
         end
         if (grant_d) begin
            lat_addr  <= bus.d_pmem_address;
            lat_wdata <= bus.d_pmem_wdata;
            lat_write <= bus.d_pmem_write;
            last_d    <= 1'b1;
            if (~&d_grant_cnt) d_grant_cnt <= d_grant_cnt + cnt_w'(1);
            // Read and write together is illegal; the write wins, flag sticks.
            if (bus.d_pmem_read & bus.d_pmem_write) op_error <= 1'b1;
         end
         if ((state == IDLE) & req_i & req_d & ~&conflict_cnt)
            conflict_cnt <= conflict_cnt + cnt_w'(1);
      end
   end

endmodule

// File: tb/tb_cache_pmem_arbiter.sv
// Directed bench for cache_pmem_arbiter: reset, single fill, contention,
// writeback address/data hold, stray response and illegal D-side op.
module tb_cache_pmem_arbiter;
   localparam int L = 256;
   localparam int A = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [31:0]   i_grant_cnt, d_grant_cnt, conflict_cnt;
   logic          op_error;
   int            tests_run = 0;
   int            tests_failed = 0;

   cache_pmem_arbiter_if #(.s_line(L), .s_addr(A)) bus ();

   cache_pmem_arbiter #(.s_line(L), .s_addr(A), .cnt_w(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus.slave),
      .i_grant_cnt  (i_grant_cnt),
      .d_grant_cnt  (d_grant_cnt),
      .conflict_cnt (conflict_cnt),
      .op_error     (op_error)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // Plays memory for one transaction; returns what it saw, compares nothing.
   task automatic mem_cycle(input int lat, input logic [L-1:0] data,
                            input bit drop_i, input bit drop_d,
                            input int chg_cycle, input logic [A-1:0] chg_addr,
                            output logic [A-1:0] addr, output logic wr,
                            output logic [L-1:0] wd, output logic ir,
                            output logic dr, output logic [L-1:0] ird,
                            output int stable, output bit timeout);
      int w;
      w = 0; timeout = 1'b0; addr = '0; wr = 1'b0; wd = '0;
      ir = 1'b0; dr = 1'b0; ird = '0; stable = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!(bus.pmem_read | bus.pmem_write) && w < 50);
      if (!(bus.pmem_read | bus.pmem_write)) begin
         timeout = 1'b1;
         return;
      end
      addr = bus.pmem_address; wr = bus.pmem_write; wd = bus.pmem_wdata;
      stable = 1;
      for (int c = 2; c <= lat; c++) begin
         if (c == chg_cycle) begin
            bus.d_pmem_address = chg_addr;
            bus.d_pmem_wdata   = ~bus.d_pmem_wdata;
         end
         @(negedge clk);
         if (bus.pmem_read == !wr && bus.pmem_write == wr &&
             bus.pmem_address == addr && bus.pmem_wdata == wd) stable++;
      end
      bus.pmem_rdata = data;
      bus.pmem_resp  = 1'b1;
      #1;
      ir = bus.i_pmem_resp; dr = bus.d_pmem_resp; ird = bus.i_pmem_rdata;
      if (drop_i) bus.i_pmem_read = 1'b0;
      if (drop_d) begin
         bus.d_pmem_read  = 1'b0;
         bus.d_pmem_write = 1'b0;
      end
      @(negedge clk);
      bus.pmem_resp = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      tests_run++;
      if ({bus.pmem_read, bus.pmem_write, bus.i_pmem_resp, bus.d_pmem_resp} !== 4'b0) begin
         tests_failed++;
         $display("FAIL reset_strobes: got %b expected 0000",
                  {bus.pmem_read, bus.pmem_write, bus.i_pmem_resp, bus.d_pmem_resp});
      end
      tests_run++;
      if ({i_grant_cnt, d_grant_cnt, conflict_cnt, op_error} !== 97'd0) begin
         tests_failed++;
         $display("FAIL reset_counters: got %0d %0d %0d %b expected 0 0 0 0",
                  i_grant_cnt, d_grant_cnt, conflict_cnt, op_error);
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_op();
      int w;
      bus.d_pmem_write = 1'b1; bus.d_pmem_address = 32'h80;
      bus.d_pmem_wdata = {8{32'hA5A5_0F0F}};
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!bus.pmem_write && w < 20);
      tests_run++;
      if (bus.pmem_write !== 1'b1 || d_grant_cnt !== 32'd1) begin
         tests_failed++;
         $display("FAIL midop_busy: pmem_write=%b d_grant=%0d expected 1 1",
                  bus.pmem_write, d_grant_cnt);
      end
      #2 rst = 1'b0;
      bus.pmem_resp = 1'b1;
      #1;
      tests_run++;
      if ({bus.pmem_write, bus.d_pmem_resp} !== 2'b00) begin
         tests_failed++;
         $display("FAIL midop_async_drop: got write=%b dresp=%b expected 0 0",
                  bus.pmem_write, bus.d_pmem_resp);
      end
      tests_run++;
      if ({i_grant_cnt, d_grant_cnt, conflict_cnt} !== 96'd0) begin
         tests_failed++;
         $display("FAIL midop_counters: got %0d %0d %0d expected 0 0 0",
                  i_grant_cnt, d_grant_cnt, conflict_cnt);
      end
      bus.d_pmem_write = 1'b0;
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({bus.pmem_read, bus.pmem_write} !== 2'b00) begin
         tests_failed++;
         $display("FAIL midop_idle_after: got %b expected 00",
                  {bus.pmem_read, bus.pmem_write});
      end
   endtask

   task automatic test_single_i();
      logic [A-1:0] addr; logic wr, ir, dr; logic [L-1:0] wd, ird;
      int st; bit to;
      logic [L-1:0] pat;
      pat = {16'hDEAD, {14{16'h1234}}, 16'hBEEF};
      bus.i_pmem_read = 1'b1; bus.i_pmem_address = 32'h0000_1A40;
      mem_cycle(5, pat, 1'b1, 1'b0, 0, '0, addr, wr, wd, ir, dr, ird, st, to);
      tests_run++;
      if (to || addr !== 32'h0000_1A40 || wr !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_i_addr: got %h wr=%b to=%b expected 00001a40 wr=0", addr, wr, to);
      end
      tests_run++;
      if (st !== 5) begin
         tests_failed++;
         $display("FAIL single_i_hold: got %0d stable cycles expected 5", st);
      end
      tests_run++;
      if (ir !== 1'b1 || dr !== 1'b0 || ird !== pat) begin
         tests_failed++;
         $display("FAIL single_i_resp: got ir=%b dr=%b rdata=%h expected 1 0 %h", ir, dr, ird, pat);
      end
      tests_run++;
      if ({bus.pmem_read, bus.i_pmem_resp} !== 2'b00 || i_grant_cnt !== 32'd1) begin
         tests_failed++;
         $display("FAIL single_i_after: read=%b iresp=%b igrant=%0d expected 0 0 1",
                  bus.pmem_read, bus.i_pmem_resp, i_grant_cnt);
      end
   endtask

   task automatic test_simultaneous();
      logic [A-1:0] addr; logic wr, ir, dr; logic [L-1:0] wd, ird;
      int st; bit to;
      do_reset();
      bus.i_pmem_read = 1'b1; bus.i_pmem_address = 32'h100;
      bus.d_pmem_read = 1'b1; bus.d_pmem_address = 32'h200;
      mem_cycle(2, '1, 1'b1, 1'b0, 0, '0, addr, wr, wd, ir, dr, ird, st, to);
      tests_run++;
      if (to || addr !== 32'h100 || ir !== 1'b1 || dr !== 1'b0) begin
         tests_failed++;
         $display("FAIL simul_first: got addr=%h ir=%b dr=%b expected 100 1 0", addr, ir, dr);
      end
      tests_run++;
      if ({bus.pmem_read, bus.pmem_write} !== 2'b00) begin
         tests_failed++;
         $display("FAIL simul_bubble: got %b expected 00", {bus.pmem_read, bus.pmem_write});
      end
      mem_cycle(2, '0, 1'b0, 1'b1, 0, '0, addr, wr, wd, ir, dr, ird, st, to);
      tests_run++;
      if (to || addr !== 32'h200 || ir !== 1'b0 || dr !== 1'b1) begin
         tests_failed++;
         $display("FAIL simul_second: got addr=%h ir=%b dr=%b expected 200 0 1", addr, ir, dr);
      end
      tests_run++;
      if (conflict_cnt !== 32'd1) begin
         tests_failed++;
         $display("FAIL simul_conflict: got %0d expected 1", conflict_cnt);
      end
   endtask

   task automatic test_contention();
      logic [A-1:0] addr; logic wr, ir, dr; logic [L-1:0] wd, ird;
      int st; bit to;
      do_reset();
      bus.i_pmem_read = 1'b1; bus.i_pmem_address = 32'h1000;
      bus.d_pmem_read = 1'b1; bus.d_pmem_address = 32'h2000;
      for (int k = 0; k < 6; k++) begin
         mem_cycle(1 + k % 3, '0, k == 5, k == 5, 0, '0, addr, wr, wd, ir, dr, ird, st, to);
         tests_run++;
         if (to || ir !== (k % 2 == 0) || dr !== (k % 2 == 1) ||
             addr !== ((k % 2 == 0) ? 32'h1000 : 32'h2000)) begin
            tests_failed++;
            $display("FAIL contention_order[%0d]: got addr=%h ir=%b dr=%b expected side %s",
                     k, addr, ir, dr, (k % 2 == 0) ? "I" : "D");
         end
      end
      tests_run++;
      if (i_grant_cnt !== 32'd3 || d_grant_cnt !== 32'd3 || conflict_cnt !== 32'd6) begin
         tests_failed++;
         $display("FAIL contention_counts: got %0d %0d %0d expected 3 3 6",
                  i_grant_cnt, d_grant_cnt, conflict_cnt);
      end
   endtask

   task automatic test_writeback_fill();
      logic [A-1:0] addr; logic wr, ir, dr; logic [L-1:0] wd, ird;
      int st; bit to;
      logic [L-1:0] pat_a;
      pat_a = {8{32'h0123_4567}};
      bus.d_pmem_write = 1'b1; bus.d_pmem_address = 32'h80; bus.d_pmem_wdata = pat_a;
      mem_cycle(4, '0, 1'b0, 1'b1, 2, 32'h3C0, addr, wr, wd, ir, dr, ird, st, to);
      tests_run++;
      if (to || addr !== 32'h80 || wr !== 1'b1 || wd !== pat_a || dr !== 1'b1) begin
         tests_failed++;
         $display("FAIL wb_latched: got addr=%h wr=%b dr=%b wdata=%h expected 80 1 1 %h",
                  addr, wr, dr, wd, pat_a);
      end
      tests_run++;
      if (st !== 4) begin
         tests_failed++;
         $display("FAIL wb_hold: got %0d stable cycles expected 4", st);
      end
      bus.d_pmem_read = 1'b1;
      mem_cycle(2, '0, 1'b0, 1'b1, 0, '0, addr, wr, wd, ir, dr, ird, st, to);
      tests_run++;
      if (to || addr !== 32'h3C0 || wr !== 1'b0 || dr !== 1'b1) begin
         tests_failed++;
         $display("FAIL wb_next_fill: got addr=%h wr=%b dr=%b expected 3c0 0 1", addr, wr, dr);
      end
   endtask

   task automatic test_stray_illegal();
      logic [A-1:0] addr; logic wr, ir, dr; logic [L-1:0] wd, ird;
      int st; bit to;
      do_reset();
      bus.pmem_resp = 1'b1;
      #1;
      tests_run++;
      if ({bus.i_pmem_resp, bus.d_pmem_resp} !== 2'b00) begin
         tests_failed++;
         $display("FAIL stray_resp: got %b expected 00", {bus.i_pmem_resp, bus.d_pmem_resp});
      end
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      tests_run++;
      if ({bus.pmem_read, bus.pmem_write} !== 2'b00 || op_error !== 1'b0) begin
         tests_failed++;
         $display("FAIL stray_idle: got strobes=%b err=%b expected 00 0",
                  {bus.pmem_read, bus.pmem_write}, op_error);
      end
      bus.d_pmem_read = 1'b1; bus.d_pmem_write = 1'b1; bus.d_pmem_address = 32'h40;
      mem_cycle(2, '0, 1'b0, 1'b1, 0, '0, addr, wr, wd, ir, dr, ird, st, to);
      tests_run++;
      if (to || wr !== 1'b1 || addr !== 32'h40 || dr !== 1'b1) begin
         tests_failed++;
         $display("FAIL illegal_write_wins: got wr=%b addr=%h dr=%b expected 1 40 1", wr, addr, dr);
      end
      tests_run++;
      if (op_error !== 1'b1 || d_grant_cnt !== 32'd1) begin
         tests_failed++;
         $display("FAIL illegal_flag: got err=%b dgrant=%0d expected 1 1", op_error, d_grant_cnt);
      end
   endtask

   initial begin
      bus.i_pmem_read = 1'b0; bus.i_pmem_address = '0;
      bus.d_pmem_read = 1'b0; bus.d_pmem_write = 1'b0;
      bus.d_pmem_address = '0; bus.d_pmem_wdata = '0;
      bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
      test_reset();
      test_reset_mid_op();
      test_single_i();
      test_simultaneous();
      test_contention();
      test_writeback_fill();
      test_stray_illegal();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
